// File: rtl/ws2812_rx.sv
// WS2812B one-wire GRB receiver: recovers 24-bit words, LED index and frame ends.
// Define WS2812_RX_GLITCH_EN to drop high pulses shorter than T_MIN_HIGH.
module ws2812_rx #(
    parameter int T_THRESH   = 60,
    parameter int T_MAX_HIGH = 150,
    parameter int T_RESET    = 28000,
    parameter int T_MIN_HIGH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] grb,
    output logic        grb_valid,
    output logic [7:0]  led_index,
    output logic        frame_done,
    output logic [7:0]  frame_leds,
    output logic        err_long,
    output logic        err_partial
);

`ifdef WS2812_RX_GLITCH_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    // Counters hold (cycles - 1) at the decision point, hence the -1 limits.
    localparam logic [15:0] THR_M1  = 16'(T_THRESH - 1);
    localparam logic [15:0] MAXH_M1 = 16'(T_MAX_HIGH - 1);
    localparam logic [15:0] RST_M1  = 16'(T_RESET - 1);
    localparam logic [15:0] MINH_M1 = 16'(T_MIN_HIGH - 1);

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t      state, state_n;
    logic        din_q, din_s;
    logic [15:0] hcnt, hcnt_n, lcnt, lcnt_n;
    logic [15:0] hcnt_inc, lcnt_inc;
    logic [22:0] sr, sr_n;
    logic [4:0]  bitcnt, bitcnt_n;
    logic [7:0]  wordcnt, wordcnt_n;
    logic        got_bit, got_bit_n;
    logic [23:0] grb_n;
    logic [7:0]  led_index_n, frame_leds_n;
    logic        grb_valid_n, frame_done_n, err_long_n, err_partial_n;
    logic        bit_v, glitch;

    assign hcnt_inc = (hcnt == 16'hFFFF) ? hcnt : hcnt + 16'd1;
    assign lcnt_inc = (lcnt == 16'hFFFF) ? lcnt : lcnt + 16'd1;
    assign bit_v    = (hcnt >= THR_M1);
    assign glitch   = GLITCH_EN && (hcnt < MINH_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q <= 1'b0;
            din_s <= 1'b0;
        end else begin
            din_q <= din;
            din_s <= din_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RESYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            sr          <= '0;
            bitcnt      <= '0;
            wordcnt     <= '0;
            got_bit     <= 1'b0;
            grb         <= '0;
            grb_valid   <= 1'b0;
            led_index   <= '0;
            frame_done  <= 1'b0;
            frame_leds  <= '0;
            err_long    <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            lcnt        <= lcnt_n;
            sr          <= sr_n;
            bitcnt      <= bitcnt_n;
            wordcnt     <= wordcnt_n;
            got_bit     <= got_bit_n;
            grb         <= grb_n;
            grb_valid   <= grb_valid_n;
            led_index   <= led_index_n;
            frame_done  <= frame_done_n;
            frame_leds  <= frame_leds_n;
            err_long    <= err_long_n;
            err_partial <= err_partial_n;
        end
    end

    always_comb begin
        state_n       = state;
        hcnt_n        = hcnt;
        lcnt_n        = lcnt;
        sr_n          = sr;
        bitcnt_n      = bitcnt;
        wordcnt_n     = wordcnt;
        got_bit_n     = got_bit;
        grb_n         = grb;
        led_index_n   = led_index;
        frame_leds_n  = frame_leds;
        grb_valid_n   = 1'b0;
        frame_done_n  = 1'b0;
        err_long_n    = 1'b0;
        err_partial_n = 1'b0;
        unique case (state)
            RESYNC: begin
                if (din_s) begin
                    lcnt_n = '0;
                end else if (lcnt >= RST_M1) begin
                    lcnt_n  = '0;
                    state_n = IDLE;
                end else begin
                    lcnt_n = lcnt_inc;
                end
            end
            IDLE: begin
                if (din_s) begin
                    hcnt_n  = '0;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (din_s) begin
                    if (hcnt >= MAXH_M1) begin
                        err_long_n = 1'b1;
                        sr_n       = '0;
                        bitcnt_n   = '0;
                        wordcnt_n  = '0;
                        got_bit_n  = 1'b0;
                        lcnt_n     = '0;
                        state_n    = RESYNC;
                    end else begin
                        hcnt_n = hcnt_inc;
                    end
                end else if (glitch) begin
                    // lcnt kept so the low time spans the glitch
                    state_n = LOW;
                end else begin
                    sr_n      = {sr[21:0], bit_v};
                    got_bit_n = 1'b1;
                    lcnt_n    = '0;
                    state_n   = LOW;
                    if (bitcnt == 5'd23) begin
                        grb_n       = {sr, bit_v};
                        grb_valid_n = 1'b1;
                        led_index_n = wordcnt;
                        wordcnt_n   = wordcnt + 8'd1;
                        bitcnt_n    = '0;
                    end else begin
                        bitcnt_n = bitcnt + 5'd1;
                    end
                end
            end
            LOW: begin
                if (din_s) begin
                    hcnt_n  = '0;
                    state_n = HIGH;
                end else if (lcnt >= RST_M1) begin
                    state_n = IDLE;
                    lcnt_n  = '0;
                    if (got_bit) begin
                        frame_done_n  = 1'b1;
                        frame_leds_n  = wordcnt;
                        err_partial_n = (bitcnt != 5'd0);
                        wordcnt_n     = '0;
                        bitcnt_n      = '0;
                        sr_n          = '0;
                        got_bit_n     = 1'b0;
                    end
                end else begin
                    lcnt_n = lcnt_inc;
                end
            end
            default: state_n = RESYNC;
        endcase
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: frame table plus resync, timing, error and glitch sequences.
// Uses a shortened reset code so the whole run stays small.
module tb_ws2812_rx;

    localparam int TRST   = 2000;
    localparam int LOWRST = TRST + 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] grb;
    logic        grb_valid;
    logic [7:0]  led_index;
    logic        frame_done;
    logic [7:0]  frame_leds;
    logic        err_long;
    logic        err_partial;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] vq_grb[$];
    logic [7:0]  vq_idx[$];
    logic [7:0]  fq_leds[$];
    logic        fq_part[$];
    int          n_long  = 0;
    int          n_stray = 0;

    always #5 clk = ~clk;

    ws2812_rx #(
        .T_THRESH  (60),
        .T_MAX_HIGH(150),
        .T_RESET   (TRST),
        .T_MIN_HIGH(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .grb        (grb),
        .grb_valid  (grb_valid),
        .led_index  (led_index),
        .frame_done (frame_done),
        .frame_leds (frame_leds),
        .err_long   (err_long),
        .err_partial(err_partial)
    );

    always @(negedge clk) begin
        if (grb_valid) begin
            vq_grb.push_back(grb);
            vq_idx.push_back(led_index);
        end
        if (frame_done) begin
            fq_leds.push_back(frame_leds);
            fq_part.push_back(err_partial);
        end
        if (err_partial && !frame_done) n_stray++;
        if (err_long) n_long++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        din = 1'b1;
        gap(h);
        din = 1'b0;
        gap(l);
    endtask

    task automatic bit_tx(input logic b);
        if (b) pulse(80, 45);
        else pulse(40, 85);
    endtask

    task automatic send_range(input logic [23:0] w, input int from, input int n);
        for (int i = from; i < from + n; i++) bit_tx(w[23-i]);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " grb"}, 32'(grb), 32'h0);
        chk({tag, " grb_valid"}, 32'(grb_valid), 32'h0);
        chk({tag, " led_index"}, 32'(led_index), 32'h0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, " frame_leds"}, 32'(frame_leds), 32'h0);
        chk({tag, " err_long"}, 32'(err_long), 32'h0);
        chk({tag, " err_partial"}, 32'(err_partial), 32'h0);
    endtask

    typedef struct {
        logic [47:0] bits;
        int          nbits;
        int          exp_nv;
        logic [23:0] exp_grb;
        logic [7:0]  exp_first_idx;
        logic [7:0]  exp_last_idx;
        logic [7:0]  exp_leds;
        logic        exp_part;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int vs, fs, ls;
        logic [47:0] b48;

        vecs[0] = '{48'h80FF01_000000, 24, 1, 24'h80FF01, 8'd0, 8'd0, 8'd1, 1'b0};
        vecs[1] = '{48'h000001_FFFFFF, 48, 2, 24'hFFFFFF, 8'd0, 8'd1, 8'd2, 1'b0};
        vecs[2] = '{48'hABCDEF_000000, 12, 0, 24'h000000, 8'd0, 8'd0, 8'd0, 1'b1};
        vecs[3] = '{48'h5A5A5A_000000, 24, 1, 24'h5A5A5A, 8'd0, 8'd0, 8'd1, 1'b0};

        din   = 1'b0;
        reset = 1'b1;
        gap(4);
        chk_reset_outs("rst");
        @(negedge clk);
        reset = 1'b0;
        gap(2);

        // Still in RESYNC: a full word after a short low must be ignored.
        vs = vq_grb.size();
        fs = fq_leds.size();
        ls = n_long;
        gap(1000);
        send_range(24'h80FF01, 0, 24);
        gap(LOWRST);
        chk("resync valids", 32'(vq_grb.size() - vs), 32'd0);
        chk("resync frames", 32'(fq_leds.size() - fs), 32'd0);
        chk("resync errlong", 32'(n_long - ls), 32'd0);

        for (int v = 0; v < 4; v++) begin
            vs  = vq_grb.size();
            fs  = fq_leds.size();
            b48 = vecs[v].bits;
            for (int i = 0; i < vecs[v].nbits; i++) bit_tx(b48[47-i]);
            gap(LOWRST);
            chk($sformatf("v%0d nvalid", v), 32'(vq_grb.size() - vs), 32'(vecs[v].exp_nv));
            if (vecs[v].exp_nv > 0) begin
                chk($sformatf("v%0d first_idx", v),
                    32'((vq_idx.size() > vs) ? vq_idx[vs] : 8'hEE),
                    32'(vecs[v].exp_first_idx));
                chk($sformatf("v%0d last_idx", v),
                    32'((vq_idx.size() > vs) ? vq_idx[vq_idx.size()-1] : 8'hEE),
                    32'(vecs[v].exp_last_idx));
                chk($sformatf("v%0d grb", v),
                    32'((vq_grb.size() > vs) ? vq_grb[vq_grb.size()-1] : 24'hEEEEEE),
                    32'(vecs[v].exp_grb));
            end
            chk($sformatf("v%0d nframes", v), 32'(fq_leds.size() - fs), 32'd1);
            chk($sformatf("v%0d frame_leds", v),
                32'((fq_leds.size() > fs) ? fq_leds[fs] : 8'hEE), 32'(vecs[v].exp_leds));
            chk($sformatf("v%0d err_partial", v),
                32'((fq_part.size() > fs) ? 32'(fq_part[fs]) : 32'hE), 32'(vecs[v].exp_part));
        end

        // grb_valid lands exactly three edges after din falls on bit 24.
        send_range(24'h0F0F0F, 0, 23);
        din = 1'b1;
        gap(80);
        din = 1'b0;
        gap(2);
        chk("tim valid early", 32'(grb_valid), 32'd0);
        gap(1);
        chk("tim valid", 32'(grb_valid), 32'd1);
        chk("tim grb", 32'(grb), 32'h0F0F0F);
        gap(1);
        chk("tim valid late", 32'(grb_valid), 32'd0);
        gap(LOWRST);

        // Overlong high mid-word, then bits that must be ignored until resync.
        ls = n_long;
        vs = vq_grb.size();
        fs = fq_leds.size();
        send_range(24'hF00000, 0, 5);
        pulse(200, 85);
        chk("long pulses", 32'(n_long - ls), 32'd1);
        send_range(24'h123456, 0, 24);
        gap(LOWRST);
        chk("long valids", 32'(vq_grb.size() - vs), 32'd0);
        chk("long frames", 32'(fq_leds.size() - fs), 32'd0);
        send_range(24'h00FF00, 0, 24);
        gap(LOWRST);
        chk("post long nvalid", 32'(vq_grb.size() - vs), 32'd1);
        chk("post long grb",
            32'((vq_grb.size() > vs) ? vq_grb[vs] : 24'hEEEEEE), 32'h00FF00);
        chk("post long idx",
            32'((vq_idx.size() > vs) ? vq_idx[vs] : 8'hEE), 32'd0);
        chk("post long leds",
            32'((fq_leds.size() > fs) ? fq_leds[fs] : 8'hEE), 32'd1);

        // 5-cycle glitch after the eighth bit of 0x123456.
        vs = vq_grb.size();
        fs = fq_leds.size();
        send_range(24'h123456, 0, 8);
        pulse(5, 80);
        send_range(24'h123456, 8, 16);
        gap(LOWRST);
        chk("glitch nvalid", 32'(vq_grb.size() - vs), 32'd1);
        chk("glitch nframes", 32'(fq_leds.size() - fs), 32'd1);
        chk("glitch leds",
            32'((fq_leds.size() > fs) ? fq_leds[fs] : 8'hEE), 32'd1);
`ifdef WS2812_RX_GLITCH_EN
        chk("glitch grb",
            32'((vq_grb.size() > vs) ? vq_grb[vs] : 24'hEEEEEE), 32'h123456);
        chk("glitch partial",
            32'((fq_part.size() > fs) ? 32'(fq_part[fs]) : 32'hE), 32'd0);
`else
        chk("glitch grb",
            32'((vq_grb.size() > vs) ? vq_grb[vs] : 24'hEEEEEE), 32'h121A2B);
        chk("glitch partial",
            32'((fq_part.size() > fs) ? 32'(fq_part[fs]) : 32'hE), 32'd1);
`endif

        // Reset mid-frame clears outputs and forces a fresh resync.
        send_range(24'hFFFFFF, 0, 10);
        reset = 1'b1;
        gap(3);
        chk_reset_outs("midrst");
        @(negedge clk);
        reset = 1'b0;
        gap(1);
        vs = vq_grb.size();
        fs = fq_leds.size();
        send_range(24'hA5A5A5, 0, 24);
        gap(LOWRST);
        chk("midrst valids", 32'(vq_grb.size() - vs), 32'd0);
        chk("midrst frames", 32'(fq_leds.size() - fs), 32'd0);
        chk("stray partial", 32'(n_stray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
